hs_syn_src_mc: RTL and testbench

Multi-channel source-side handshake engine for the `clkA` domain. It collects rising-edge events on CH independent inputs and queues them in per-channel saturating counters, so that events arriving while a transfer is in progress are no longer lost. It serialises pending events round-robin onto a single 4-phase req/ack handshake toward the `clkB` domain. The ack returning from `clkB` is synchronised internally.

---
 rtl/hs_syn_src_mc.sv | 105 ++++++++++
 tb/tb_hs_syn_src_mc.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/hs_syn_src_mc.sv
// hs_syn_src_mc: per-channel event queues serialised round-robin onto one 4-phase req/ack handshake.
// Define HS_SYN_DROP_CNT_EN to add the 16-bit saturating drop_cnt output.
module hs_syn_src_mc #(
    parameter int CH       = 4,
    parameter int CNT_W    = 4,
    parameter int SYNC_STG = 2
) (
    input  logic                  clkA,
    input  logic                  resetA,
    input  logic [CH-1:0]         inA,
    input  logic                  ackB,
    output logic                  reqA,
    output logic [$clog2(CH)-1:0] chA,
    output logic                  busy,
    output logic [CH-1:0]         pend,
    output logic [CH-1:0]         ovf,
    input  logic [CH-1:0]         ovf_clr
`ifdef HS_SYN_DROP_CNT_EN
    ,
    output logic [15:0]           drop_cnt
`endif
);
    localparam int CW = $clog2(CH);
    typedef enum logic [1:0] {IDLE, REQ, REL} state_t;
    state_t r_state, w_state_nxt;
    logic [SYNC_STG-1:0] r_ack_sync;
    logic [CH-1:0] r_in_q, r_ovf, w_rise, w_dec, w_drop;
    logic [CNT_W-1:0] r_cnt [CH];
    logic [CW-1:0] r_ch, r_last, w_gnt_ch;
    logic [CW:0] w_idx;
    logic r_req, w_ack_s, w_grant;

    assign w_ack_s = r_ack_sync[SYNC_STG-1];
    assign w_rise  = inA & ~r_in_q;
    assign w_grant = (r_state == IDLE) && (|pend) && !w_ack_s;
    assign w_dec   = w_grant ? (CH'(1) << w_gnt_ch) : '0;
    assign reqA    = r_req;
    assign chA     = r_ch;
    assign busy    = r_state != IDLE;
    assign ovf     = r_ovf;

    // Scan downward so the closest pending channel after r_last wins.
    always_comb begin
        w_idx    = '0;
        w_gnt_ch = '0;
        for (int k = CH; k >= 1; k--) begin
            w_idx = {1'b0, r_last} + (CW+1)'(k);
            if (w_idx >= (CW+1)'(CH)) w_idx = w_idx - (CW+1)'(CH);
            if (pend[w_idx[CW-1:0]]) w_gnt_ch = w_idx[CW-1:0];
        end
    end

    always_comb begin
        pend   = '0;
        w_drop = '0;
        for (int i = 0; i < CH; i++) begin
            pend[i]   = |r_cnt[i];
            w_drop[i] = w_rise[i] && !w_dec[i] && (&r_cnt[i]);
        end
    end

    always_comb begin
        w_state_nxt = (r_state == IDLE && w_grant)  ? REQ  :
                      (r_state == REQ  && w_ack_s)  ? REL  :
                      (r_state == REL  && !w_ack_s) ? IDLE : r_state;
    end

    always_ff @(posedge clkA or negedge resetA) begin
        if (!resetA) begin
            r_state    <= IDLE;
            r_req      <= 1'b0;
            r_ch       <= '0;
            r_last     <= CW'(CH-1);
            r_ack_sync <= '0;
            r_in_q     <= '0;
            r_ovf      <= '0;
            for (int i = 0; i < CH; i++) r_cnt[i] <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_req      <= w_state_nxt == REQ;
            r_ack_sync <= {r_ack_sync[SYNC_STG-2:0], ackB};
            r_in_q     <= inA;
            r_ovf      <= w_drop | (r_ovf & ~ovf_clr);
            if (w_grant) begin
                r_ch   <= w_gnt_ch;
                r_last <= w_gnt_ch;
            end
            for (int i = 0; i < CH; i++) begin
                if (w_rise[i] && !w_dec[i] && !w_drop[i]) r_cnt[i] <= r_cnt[i] + 1'b1;
                else if (w_dec[i] && !w_rise[i]) r_cnt[i] <= r_cnt[i] - 1'b1;
            end
        end
    end

`ifdef HS_SYN_DROP_CNT_EN
    logic [15:0] r_drop;
    logic [16:0] w_drop_sum;
    assign w_drop_sum = {1'b0, r_drop} + 17'($countones(w_drop));
    assign drop_cnt   = r_drop;
    always_ff @(posedge clkA or negedge resetA) begin
        if (!resetA) r_drop <= '0;
        else r_drop <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
    end
`endif
endmodule

// File: tb/tb_hs_syn_src_mc.sv
// tb_hs_syn_src_mc: scoreboard bench; expected grant channels are queued at stimulus and popped on each reqA rise.
module tb_hs_syn_src_mc;
    logic clkA = 0, clkB = 0, resetA = 0, ackB = 0;
    logic [3:0] inA = 0, ovf_clr = 0, pend, ovf;
    logic reqA, busy, prev_req = 0;
    logic [1:0] chA, r_b;
    int ack_mode = 0, checks = 0, errors = 0, hs_cnt = 0;
    int exp_q[$];
`ifdef HS_SYN_DROP_CNT_EN
    logic [15:0] drop_cnt;
`endif

    hs_syn_src_mc #(.CH(4), .CNT_W(4), .SYNC_STG(2)) dut (
        .clkA(clkA), .resetA(resetA), .inA(inA), .ackB(ackB), .reqA(reqA), .chA(chA),
        .busy(busy), .pend(pend), .ovf(ovf), .ovf_clr(ovf_clr)
`ifdef HS_SYN_DROP_CNT_EN
        , .drop_cnt(drop_cnt)
`endif
    );

    always #5 clkA = ~clkA;
    always #7 clkB = ~clkB;

    // clkB side: ack follows req after 3 clkB edges, or is forced low/high.
    always @(posedge clkB or negedge resetA) begin
        if (!resetA) begin
            r_b  <= 0;
            ackB <= (ack_mode == 2);
        end else begin
            r_b  <= {r_b[0], reqA};
            ackB <= (ack_mode == 2) ? 1'b1 : (ack_mode == 1) ? 1'b0 : r_b[1];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clkA) begin
        if (resetA && reqA && !prev_req) begin
            hs_cnt++;
            if (exp_q.size() == 0) check("req_without_expect", 32'(exp_q.size()), 1);
            else check("grant_ch", 32'(chA), 32'(exp_q.pop_front()));
        end
        prev_req <= reqA;
    end

    task automatic do_reset(input int mode);
        ack_mode = mode;
        inA = 0;
        ovf_clr = 0;
        resetA = 0;
        exp_q.delete();
        repeat (3) @(negedge clkA);
        resetA = 1;
        hs_cnt = 0;
    endtask

    task automatic pulse(input logic [3:0] m);
        @(negedge clkA) inA = m;
        @(negedge clkA) inA = 0;
    endtask

    task automatic wait_idle(input int max_cyc);
        logic done = 0;
        for (int n = 0; n < max_cyc && !done; n++) begin
            @(negedge clkA);
            done = (exp_q.size() == 0) && !busy && (pend == 0);
        end
        check("wait_idle", 32'(done), 1);
    endtask

    initial begin
        do_reset(0);
        @(negedge clkA);
        check("rst_reqA", 32'(reqA), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_chA", 32'(chA), 0);
        check("rst_pend", 32'(pend), 0);
        check("rst_ovf", 32'(ovf), 0);

        // single event on ch0
        exp_q.push_back(0);
        pulse(4'b0001);
        wait_idle(500);
        check("t1_hs", 32'(hs_cnt), 1);
        check("t1_pend", 32'(pend), 0);
        check("t1_busy", 32'(busy), 0);

        // simultaneous events: round-robin from channel 0
        do_reset(0);
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(3);
        pulse(4'b1011);
        wait_idle(1000);
        check("t2_hs", 32'(hs_cnt), 3);

        // ack high from reset blocks grants; 20 events saturate ch2
        do_reset(2);
        repeat (5) @(negedge clkA);
        for (int p = 0; p < 20; p++) pulse(4'b0100);
        repeat (3) @(negedge clkA);
        check("t3_no_req", 32'(hs_cnt), 0);
        check("t3_reqA", 32'(reqA), 0);
        check("t3_pend", 32'(pend), 32'b0100);
        check("t3_ovf", 32'(ovf), 32'b0100);
`ifdef HS_SYN_DROP_CNT_EN
        check("t3_drop_cnt", 32'(drop_cnt), 5);
`endif
        @(negedge clkA) ovf_clr = 4'b0100;
        @(negedge clkA) ovf_clr = 0;
        check("t3_ovf_clr", 32'(ovf), 0);
        for (int p = 0; p < 15; p++) exp_q.push_back(2);
        ack_mode = 0;
        wait_idle(3000);
        check("t3_hs", 32'(hs_cnt), 15);

        // new rise on ch1 in the same cycle ch1 is granted
        do_reset(0);
        exp_q.push_back(0); exp_q.push_back(1);
        pulse(4'b0011);
        for (int n = 0; n < 200 && !busy; n++) @(negedge clkA);
        for (int n = 0; n < 200 && busy; n++) @(negedge clkA);
        check("t4_pend_before", 32'(pend), 32'b0010);
        inA = 4'b0010;
        exp_q.push_back(1);
        @(negedge clkA) inA = 0;
        check("t4_pend1_kept", 32'(pend[1]), 1);
        check("t4_busy", 32'(busy), 1);
        wait_idle(1000);
        check("t4_hs", 32'(hs_cnt), 3);

        // async reset while in REQ
        do_reset(1);
        exp_q.push_back(0);
        pulse(4'b0001);
        for (int n = 0; n < 50 && !reqA; n++) @(negedge clkA);
        check("t5_reqA_up", 32'(reqA), 1);
        for (int p = 0; p < 16; p++) pulse(4'b1000);
        check("t5_ovf_pre", 32'(ovf), 32'b1000);
        check("t5_pend_pre", 32'(pend), 32'b1000);
        @(negedge clkA) #2 resetA = 0;
        #1;
        check("t5_reqA", 32'(reqA), 0);
        check("t5_busy", 32'(busy), 0);
        check("t5_pend", 32'(pend), 0);
        check("t5_ovf", 32'(ovf), 0);
        exp_q.delete();
        @(negedge clkA) resetA = 1;
        repeat (2) @(negedge clkA);

        $display("TB_RESULT checks=%0d failures=%0d", checks, errors);
        $finish;
    end
endmodule
